// File: rtl/fetch_pc_unit_if.sv
// Fetch PC unit bus: hazard/EX-stage controls in, fetch PC and RAS prediction out.
// Latency: wires only; the unit registers PCF one cycle after its controls.
// Backpressure: none; stall is the only hold and is sampled every cycle.
interface fetch_pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             ret_hint;
    logic             ras_push;
    logic [WIDTH-1:0] ras_push_addr;
    logic             ras_pop;
    logic [WIDTH-1:0] PCF;
    logic [WIDTH-1:0] PCPlus4F;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_pc;
    logic             ras_empty;
    logic             ras_full;

    // Hazard unit / EX stage side drives the controls and observes the PC.
    modport master (
        output stall, redirect, redirect_pc, ret_hint,
               ras_push, ras_push_addr, ras_pop,
        input  PCF, PCPlus4F, pred_taken, pred_pc, ras_empty, ras_full
    );

    // The fetch PC unit itself.
    modport slave (
        input  stall, redirect, redirect_pc, ret_hint,
               ras_push, ras_push_addr, ras_pop,
        output PCF, PCPlus4F, pred_taken, pred_pc, ras_empty, ras_full
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register with redirect/stall/RAS-prediction next-PC select and a circular RAS.
// Latency: next PC registered, 1 cycle, no bubble; PCPlus4F and prediction are combinational.
// Backpressure: stall holds PCF (redirect overrides it); RAS push/pop always commit.
module fetch_pc_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               PC_STEP   = 4,
    parameter int               RAS_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    fetch_pc_unit_if.slave bus
);
    localparam int               PTR_W      = $clog2(RAS_DEPTH);
    localparam int               CNT_W      = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             pred_taken;
    logic             swap_top;

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(RAS_DEPTH));
    assign pc_plus    = pc_q + WIDTH'(PC_STEP);
    assign pred_taken = bus.ret_hint & ~empty;
    // A push and pop together on a non-empty stack replaces the top in place.
    assign swap_top   = bus.ras_push & bus.ras_pop & ~empty;
    assign wr_idx     = swap_top ? top_ptr : top_ptr + PTR_W'(1);

    assign bus.PCF        = pc_q;
    assign bus.PCPlus4F   = pc_plus;
    assign bus.pred_taken = pred_taken;
    // Gate by empty so stale entries left from before reset never appear.
    assign bus.pred_pc    = empty ? '0 : ras_mem[top_ptr];
    assign bus.ras_empty  = empty;
    assign bus.ras_full   = full;

    // Next-PC priority: redirect, stall hold, RAS prediction, sequential; always word aligned.
    always_comb begin
        next_pc = pc_plus;
        if (bus.redirect) begin
            next_pc = bus.redirect_pc;
        end else if (bus.stall) begin
            next_pc = pc_q;
        end else if (pred_taken) begin
            next_pc = ras_mem[top_ptr];
        end
        next_pc = next_pc & ALIGN_MASK;
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC & ALIGN_MASK;
        end else begin
            pc_q <= next_pc;
        end
    end

    // RAS storage: contents need no reset, emptiness is tracked by count.
    always_ff @(posedge clk) begin
        if (!rst && bus.ras_push) begin
            ras_mem[wr_idx] <= bus.ras_push_addr;
        end
    end

    // RAS pointer and occupancy; a full push overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (swap_top) begin
            top_ptr <= top_ptr;
            count   <= count;
        end else if (bus.ras_push) begin
            top_ptr <= top_ptr + PTR_W'(1);
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (bus.ras_pop && !empty) begin
            top_ptr <= top_ptr - PTR_W'(1);
            count   <= count - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a queue-based reference model checked every cycle.
// Latency: model advances on each posedge, compared on the following negedge.
// Backpressure: none; inputs change 1 time unit after each posedge.
module tb_fetch_pc_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fetch_pc_unit_if #(.WIDTH(32)) bus ();

    fetch_pc_unit #(
        .WIDTH(32), .RESET_PC(32'h0), .PC_STEP(4), .RAS_DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: PC as a number, RAS as a bounded queue (oldest dropped on overflow).
    logic [31:0] mpc;
    logic [31:0] mq[$];
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        logic [31:0] npc;
        if (rst) begin
            mpc = 32'h0;
            mq.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (bus.redirect)                         npc = bus.redirect_pc;
            else if (bus.stall)                       npc = mpc;
            else if (bus.ret_hint && mq.size() > 0)   npc = mq[$];
            else                                      npc = mpc + 32'd4;
            mpc = npc & 32'hFFFF_FFFC;
            if (bus.ras_push && bus.ras_pop && mq.size() > 0) begin
                mq[mq.size()-1] = bus.ras_push_addr;
            end else if (bus.ras_push) begin
                mq.push_back(bus.ras_push_addr);
                if (mq.size() > 4) void'(mq.pop_front());
            end else if (bus.ras_pop && mq.size() > 0) begin
                void'(mq.pop_back());
            end
        end
    end

    // Compare every output against the model on each negedge once reset has been seen.
    always @(negedge clk) begin
        if (model_ok) begin
            check("pcf", bus.PCF, mpc);
            check("pcplus4f", bus.PCPlus4F, mpc + 32'd4);
            check("pred_taken", 32'(bus.pred_taken), 32'(bus.ret_hint && mq.size() > 0));
            if (bus.ret_hint && mq.size() > 0) check("pred_pc", bus.pred_pc, mq[$]);
            check("ras_empty", 32'(bus.ras_empty), 32'(mq.size() == 0));
            check("ras_full", 32'(bus.ras_full), 32'(mq.size() == 4));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.redirect = 0; bus.redirect_pc = '0; bus.ret_hint = 0;
        bus.ras_push = 0; bus.ras_push_addr = '0; bus.ras_pop = 0;
    endtask

    logic [31:0] stack_vals [5];
    logic [31:0] saved_pc;

    initial begin
        rst = 1'b1;
        idle_inputs();

        // 1: two reset cycles, then sequential fetch.
        cyc(); check("rst_pcf0", bus.PCF, 32'h0);
        check("rst_empty", 32'(bus.ras_empty), 32'd1);
        check("rst_full", 32'(bus.ras_full), 32'd0);
        check("rst_pred", 32'(bus.pred_taken), 32'd0);
        cyc(); check("rst_pcf1", bus.PCF, 32'h0);
        rst = 1'b0;
        cyc(); check("seq_pcf4", bus.PCF, 32'h4);
        cyc(); check("seq_pcf8", bus.PCF, 32'h8);
        cyc(); check("seq_pcfc", bus.PCF, 32'hC);
        cyc(); check("seq_pcf10", bus.PCF, 32'h10);

        // 2: stall with a redirect in its second cycle.
        bus.stall = 1;
        cyc(); check("stall_hold", bus.PCF, 32'h10);
        bus.redirect = 1; bus.redirect_pc = 32'h200;
        cyc(); check("redir_over_stall", bus.PCF, 32'h200);
        bus.redirect = 0;
        cyc(); check("stall_after_redir", bus.PCF, 32'h200);
        bus.stall = 0;

        // 3: push two returns, predict, pop, predict, pop to empty.
        bus.ras_push = 1; bus.ras_push_addr = 32'h104;
        cyc();
        bus.ras_push_addr = 32'h208;
        cyc();
        bus.ras_push = 0; bus.ret_hint = 1;
        #1; check("pred_top_208", bus.pred_pc, 32'h208);
        check("pred_taken_1", 32'(bus.pred_taken), 32'd1);
        cyc(); check("pcf_pred_208", bus.PCF, 32'h208);
        bus.ret_hint = 0; bus.ras_pop = 1;
        cyc();
        bus.ras_pop = 0; bus.ret_hint = 1;
        #1; check("pred_top_104", bus.pred_pc, 32'h104);
        bus.ras_pop = 1;
        cyc(); check("pcf_pred_104", bus.PCF, 32'h104);
        check("empty_after_pops", 32'(bus.ras_empty), 32'd1);
        bus.ras_pop = 0;
        #1; check("no_pred_empty", 32'(bus.pred_taken), 32'd0);
        saved_pc = bus.PCF;
        cyc(); check("empty_hint_seq", bus.PCF, saved_pc + 32'd4);
        bus.ret_hint = 0;

        // 4: overflow a 4-deep RAS, then drain and over-pop.
        for (int i = 0; i < 5; i++) begin
            stack_vals[i] = 32'h1000 + 32'(i * 4);
            bus.ras_push = 1; bus.ras_push_addr = stack_vals[i];
            cyc();
        end
        bus.ras_push = 0;
        check("full_after_5", 32'(bus.ras_full), 32'd1);
        bus.ret_hint = 1;
        for (int i = 4; i >= 1; i--) begin
            #1; check("drain_top", bus.pred_pc, stack_vals[i]);
            bus.ras_pop = 1;
            cyc();
        end
        bus.ras_pop = 0;
        check("drained_empty", 32'(bus.ras_empty), 32'd1);
        bus.ras_pop = 1;
        cyc(); check("overpop_empty", 32'(bus.ras_empty), 32'd1);
        check("overpop_full", 32'(bus.ras_full), 32'd0);
        bus.ras_pop = 0; bus.ret_hint = 0;

        // 5: simultaneous push/pop, non-empty then empty.
        bus.ras_push = 1; bus.ras_push_addr = 32'h30;
        cyc();
        bus.ras_push_addr = 32'h40;
        cyc();
        bus.ras_pop = 1; bus.ras_push_addr = 32'h50;
        cyc();
        bus.ras_push = 0; bus.ras_pop = 0; bus.ret_hint = 1;
        #1; check("swap_top_50", bus.pred_pc, 32'h50);
        bus.ras_pop = 1;
        cyc(); check("swap_count2_left1", 32'(bus.ras_empty), 32'd0);
        #1; check("swap_below_30", bus.pred_pc, 32'h30);
        cyc(); check("swap_drained", 32'(bus.ras_empty), 32'd1);
        bus.ras_push = 1; bus.ras_push_addr = 32'h50;
        cyc();
        bus.ras_push = 0; bus.ras_pop = 0;
        #1; check("empty_pushpop_top", bus.pred_pc, 32'h50);
        bus.ras_pop = 1;
        cyc(); check("empty_pushpop_cnt1", 32'(bus.ras_empty), 32'd1);
        bus.ras_pop = 0; bus.ret_hint = 0;

        // 6: alignment and wrap.
        bus.redirect = 1; bus.redirect_pc = 32'h123;
        cyc(); check("align_120", bus.PCF, 32'h120);
        bus.redirect_pc = 32'hFFFF_FFFC;
        cyc(); check("pcf_top", bus.PCF, 32'hFFFF_FFFC);
        check("pcplus_wrap", bus.PCPlus4F, 32'h0);
        bus.redirect = 0;
        cyc(); check("pcf_wrap0", bus.PCF, 32'h0);

        // Reset mid-operation discards pending stall/redirect and clears the RAS.
        bus.ras_push = 1; bus.ras_push_addr = 32'h700;
        cyc();
        bus.ras_push = 0;
        rst = 1; bus.stall = 1; bus.redirect = 1; bus.redirect_pc = 32'h400;
        cyc(); check("midrst_pcf", bus.PCF, 32'h0);
        check("midrst_empty", 32'(bus.ras_empty), 32'd1);
        rst = 0; idle_inputs();
        cyc(); check("midrst_resume", bus.PCF, 32'h4);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
